// File: rtl/imem_loader_if.sv
// Host byte stream, IMEM write port and CPU control signals of the program loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  Load_Start;
  logic [ADDR_WIDTH:0]   Load_Words;
  logic [7:0]            Byte_In;
  logic                  Byte_Valid;
  logic                  Byte_Ready;
  logic                  Mem_WrEn;
  logic [ADDR_WIDTH-1:0] Mem_Addr;
  logic [31:0]           Mem_Din;
  logic                  Cpu_Hold;
  logic                  Cpu_Reset;
  logic                  Busy;
  logic                  Done;
  logic                  Err;

  modport master (
    output Load_Start, Load_Words, Byte_In, Byte_Valid,
    input  Byte_Ready, Mem_WrEn, Mem_Addr, Mem_Din, Cpu_Hold, Cpu_Reset, Busy, Done, Err
  );

  modport slave (
    input  Load_Start, Load_Words, Byte_In, Byte_Valid,
    output Byte_Ready, Mem_WrEn, Mem_Addr, Mem_Din, Cpu_Hold, Cpu_Reset, Busy, Done, Err
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words, writes them
// to IMEM from address 0 while holding fetch, then pulses a fetch-stage reset.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input logic          Clk,
  input logic          Reset_n,
  imem_loader_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH:0]   word_cnt_inc;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  last_q, last_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_din_q, mem_din_d;
  logic                  err_q, err_d;
  logic                  byte_ready;
  logic                  xfer;

  // last_q marks the final write cycle inside LOAD: intake stops, DONE follows.
  assign byte_ready   = (state_q == S_LOAD) && !last_q;
  assign xfer         = byte_ready && bus.Byte_Valid;
  assign word_cnt_inc = word_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    addr_d     = addr_q;
    last_d     = last_q;
    wr_en_d    = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Load_Start) begin
          if ((bus.Load_Words != '0) && (bus.Load_Words <= DEPTH)) begin
            count_d    = bus.Load_Words;
            word_cnt_d = '0;
            idx_d      = '0;
            buf_d      = '0;
            addr_d     = '0;
            mem_addr_d = '0;
            last_d     = 1'b0;
            state_d    = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (last_q) begin
          state_d = S_DONE;
        end else if (xfer) begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: buf_d[7:0]   = bus.Byte_In;
            2'd1: buf_d[15:8]  = bus.Byte_In;
            2'd2: buf_d[23:16] = bus.Byte_In;
            default: begin
              mem_din_d  = {bus.Byte_In, buf_q};
              mem_addr_d = addr_q;
              addr_d     = addr_q + 1'b1;
              wr_en_d    = 1'b1;
              word_cnt_d = word_cnt_inc;
              if (word_cnt_inc == count_q) last_d = 1'b1;
            end
          endcase
        end
      end
      S_DONE: begin
        last_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      word_cnt_q <= '0;
      idx_q      <= '0;
      buf_q      <= '0;
      addr_q     <= '0;
      last_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      wr_en_q    <= wr_en_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      err_q      <= err_d;
    end
  end

  assign bus.Byte_Ready = byte_ready;
  assign bus.Mem_WrEn   = wr_en_q;
  assign bus.Mem_Addr   = mem_addr_q;
  assign bus.Mem_Din    = mem_din_q;
  assign bus.Cpu_Hold   = (state_q != S_IDLE);
  assign bus.Busy       = (state_q != S_IDLE);
  assign bus.Cpu_Reset  = (state_q == S_DONE);
  assign bus.Done       = (state_q == S_DONE);
  assign bus.Err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: stimulus queues expected IMEM writes,
// a negedge monitor pops and compares them as the DUT strobes Mem_WrEn.
module tb_imem_loader;
  localparam int AW = 10;

  logic Clk = 1'b0;
  logic Reset_n;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();
  imem_loader #(.ADDR_WIDTH(AW)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  always #5 Clk = ~Clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        sb[$];
  wr_t        exp_w;
  logic [7:0] bytes_q[$];
  int errors = 0;
  int checks = 0;
  int wr_seen = 0, done_seen = 0, rst_seen = 0, err_seen = 0;
  int exp_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (Reset_n) begin
      if (bus.Mem_WrEn) begin
        wr_seen++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                   bus.Mem_Addr, bus.Mem_Din);
        end else begin
          exp_w = sb.pop_front();
          if (bus.Mem_Addr !== exp_w.addr || bus.Mem_Din !== exp_w.data) begin
            errors++;
            $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                     bus.Mem_Addr, bus.Mem_Din, exp_w.addr, exp_w.data);
          end
        end
      end
      if (bus.Done) done_seen++;
      if (bus.Cpu_Reset) rst_seen++;
      if (bus.Err) err_seen++;
    end
  end

  // abort_after >= 0: pulse reset after that many bytes have transferred.
  task automatic do_load(input int n, input int gap_pct, input int abort_after, input bit poke);
    int nb, full, w0, r0, e0;
    int unsigned d;
    nb = 4 * n;
    while (bytes_q.size() < nb) bytes_q.push_back(8'($urandom));
    full = (abort_after < 0) ? n : abort_after / 4;
    for (int w = 0; w < full; w++) begin
      d = int'(bytes_q[4*w]) + int'(bytes_q[4*w+1]) * 256
        + int'(bytes_q[4*w+2]) * 65536 + int'(bytes_q[4*w+3]) * 16777216;
      sb.push_back('{addr: AW'(w), data: d});
    end
    w0 = wr_seen; r0 = rst_seen; e0 = err_seen;
    bus.Load_Start = 1'b1;
    bus.Load_Words = (AW+1)'(n);
    tick();
    bus.Load_Start = 1'b0;
    check("load_entry", {bus.Busy, bus.Cpu_Hold, bus.Byte_Ready}, 3'b111);
    for (int i = 0; i < nb; i++) begin
      if (i == abort_after) break;
      while ($urandom_range(99) < gap_pct) begin
        bus.Byte_Valid = 1'b0;
        tick();
      end
      if (poke && i == 5) begin
        bus.Byte_Valid = 1'b0;
        bus.Load_Start = 1'b1;
        bus.Load_Words = 11'd1;
        tick();
        bus.Load_Start = 1'b0;
      end
      bus.Byte_Valid = 1'b1;
      bus.Byte_In    = bytes_q[i];
      tick();
    end
    bus.Byte_Valid = 1'b0;
    if (abort_after >= 0) begin
      #2 Reset_n = 1'b0;
      #1 check("reset_outputs", {bus.Byte_Ready, bus.Mem_WrEn, bus.Mem_Addr, bus.Mem_Din,
                                 bus.Cpu_Hold, bus.Cpu_Reset, bus.Busy, bus.Done, bus.Err}, 64'd0);
      tick();
      Reset_n = 1'b1;
      repeat (3) tick();
      check("post_abort_idle", {bus.Byte_Ready, bus.Busy, bus.Cpu_Hold}, 3'b000);
      check("no_cpu_reset", rst_seen - r0, 0);
    end else begin
      check("last_write", {bus.Mem_WrEn, bus.Byte_Ready}, 2'b10);
      tick();
      check("done_cycle", {bus.Done, bus.Cpu_Reset, bus.Busy, bus.Cpu_Hold}, 4'b1111);
      tick();
      check("idle_after", {bus.Busy, bus.Cpu_Hold, bus.Done, bus.Cpu_Reset}, 4'b0000);
      exp_done++;
    end
    check("write_count", wr_seen - w0, full);
    check("no_err_in_load", err_seen - e0, 0);
    bytes_q.delete();
  endtask

  task automatic bad_start(input int n);
    int w0;
    w0 = wr_seen;
    bus.Load_Start = 1'b1;
    bus.Load_Words = (AW+1)'(n);
    tick();
    bus.Load_Start = 1'b0;
    check("err_pulse", {bus.Err, bus.Busy}, 2'b10);
    tick();
    check("err_clear", {bus.Err, bus.Busy, bus.Byte_Ready}, 3'b000);
    check("no_write_on_err", wr_seen - w0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n        = 1'b0;
    bus.Load_Start = 1'b0;
    bus.Load_Words = '0;
    bus.Byte_In    = '0;
    bus.Byte_Valid = 1'b0;
    #12;
    check("reset_state", {bus.Byte_Ready, bus.Mem_WrEn, bus.Mem_Addr, bus.Mem_Din,
                          bus.Cpu_Hold, bus.Cpu_Reset, bus.Busy, bus.Done, bus.Err}, 64'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    check("idle_ready", {bus.Byte_Ready, bus.Busy}, 2'b00);

    bytes_q = '{8'h13, 8'h00, 8'h20, 8'h00};
    do_load(1, 0, -1, 1'b0);
    do_load(3, 40, -1, 1'b1);
    bad_start(0);
    bad_start(1025);
    do_load(4, 20, 6, 1'b0);
    do_load(1, 0, -1, 1'b0);
    for (int k = 0; k < 3; k++) do_load($urandom_range(2, 8), 30, -1, 1'b0);
    do_load(1024, 5, -1, 1'b0);

    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);
    check("done_pulses", done_seen, exp_done);
    check("cpu_reset_pulses", rst_seen, exp_done);
    check("err_pulses", err_seen, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the instruction memory, acting as the write side of the fetch path. It accepts a byte stream from a host port and assembles bytes into 32-bit little-endian words. It writes those words to consecutive IMEM word addresses starting at 0. While loading, it holds the fetch stage, and after the last word it issues a one-cycle fetch-stage reset so execution restarts at PC = 0.

## Interface

Parameters:

- ADDR_WIDTH, 10, IMEM word-address width (matches PC[11:2]). Depth = 2^ADDR_WIDTH words.

Ports:

- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Load_Start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- Load_Words  in  ADDR_WIDTH+1  number of words to load; sampled with Load_Start.
- Byte_In  in  8  host data byte.
- Byte_Valid  in  1  Byte_In is valid.
- Byte_Ready  out  1  loader accepts a byte this cycle.
- Mem_WrEn  out  1  IMEM write strobe.
- Mem_Addr  out  ADDR_WIDTH  IMEM word address.
- Mem_Din  out  32  IMEM write data.
- Cpu_Hold  out  1  forces fetch-stage PC_LdEn low while high.
- Cpu_Reset  out  1  one-cycle reset pulse to the fetch stage.
- Busy  out  1  high in LOAD and DONE.
- Done  out  1  one-cycle pulse on load completion.
- Err  out  1  one-cycle pulse on a rejected Load_Start.

## Operation

- States: IDLE, LOAD, DONE.
- IDLE, on Load_Start:
  - If 1 ≤ Load_Words ≤ 2^ADDR_WIDTH: latch the count, clear the word counter, byte index and address, then go to LOAD.
  - Otherwise: pulse Err and stay in IDLE.
- LOAD:
  - Byte_Ready = 1.
  - A byte transfers when Byte_Valid && Byte_Ready.
  - Byte index k (0..3) places Byte_In into bits [8k+7:8k]; the first byte received is the least-significant byte.
  - On the transfer with k = 3: the assembled word is registered into Mem_Din together with the current address, the index wraps to 0, and the word counter increments.
  - Bytes keep flowing during the write cycle; the assembly buffer is independent of Mem_Din.
- Address arithmetic: Mem_Addr increments by 1 after each write, modulo 2^ADDR_WIDTH. A full-depth load ends at address 2^ADDR_WIDTH − 1, and the address never wraps during a legal load.
- On the final word's transfer, Byte_Ready drops in the next cycle and the FSM enters DONE after the write cycle.
- DONE lasts one cycle:
  - Cpu_Reset = 1 and Done = 1.
  - Next state is IDLE.
- Cpu_Hold = 1 in LOAD and DONE, and 0 in IDLE.
- Load_Start is ignored outside IDLE.
- Reset_n low, at any time and in any state:
  - Immediately sets IDLE and clears all counters.
  - Drives every output to 0 (Byte_Ready, Mem_WrEn, Mem_Addr, Mem_Din, Cpu_Hold, Cpu_Reset, Busy, Done, Err).
  - A partially assembled word is discarded. Words already written stay in IMEM, and no Cpu_Reset is issued.

## Timing

- Load_Start is accepted at edge T. From T+1 the outputs are: LOAD, Busy = 1, Cpu_Hold = 1, Byte_Ready = 1.
- The 4th byte of a word transfers at edge N. Then Mem_WrEn = 1 for exactly the cycle after N, with Mem_Addr/Mem_Din valid in that same cycle. Write latency is 1 cycle.
- The last byte transfers at edge L:
  - Cycle after L: Mem_WrEn = 1 and Byte_Ready = 0.
  - Next cycle: DONE, with Cpu_Reset = Done = 1.
  - Cycle after that: IDLE, with Cpu_Hold = Busy = 0.
- Err is asserted in the cycle after the rejected Load_Start.
- Byte_Valid may toggle freely; gaps do not affect state.
- Minimum load time is 4·Load_Words + 3 cycles from Load_Start.

## Test plan

- Reset: Reset_n low mid-cycle → all outputs 0 asynchronously; after release, state is IDLE and Byte_Ready = 0.
- Single word: Load_Words = 1, bytes 0x13, 0x00, 0x20, 0x00 back-to-back → one write, Addr 0, Din 0x00200013. Next cycle Cpu_Reset = Done = 1, then Cpu_Hold = 0.
- Three words with random Byte_Valid gaps → writes at addresses 0, 1, 2 with correct little-endian data. Exactly 3 Mem_WrEn pulses, and Byte_Ready = 0 after the 12th byte.
- Illegal count: Load_Words = 0 and Load_Words = 1025 (ADDR_WIDTH = 10) → Err pulse each time, no writes, Busy stays 0. Load_Start asserted while in LOAD → ignored.
- Reset mid-load: assert Reset_n low after 6 bytes of a 4-word load → one write (addr 0) occurs, no Cpu_Reset. A new 1-word load then writes to address 0.
- Full depth: Load_Words = 1024 → last write at address 1023, no wrap, Done pulse once.
